// File: rtl/bidir_port_pkg.sv
// Shared types and build-time constants for the bidirectional port controller.
// BIDIR_PORT_SYNC_EN selects a 2-flop input synchroniser on pad_din.
package bidir_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_TURN,
    ST_READ,
    ST_CAPTURE
  } state_e;

`ifdef BIDIR_PORT_SYNC_EN
  localparam int unsigned SYNC_STAGES = 2;
`else
  localparam int unsigned SYNC_STAGES = 0;
`endif

  // Width of the shared phase counter, sized for the longer of drive and read phases.
  function automatic int unsigned cnt_width(input int unsigned hold_cyc,
                                            input int unsigned rd_cyc);
    int unsigned m;
    m = (hold_cyc > rd_cyc) ? hold_cyc : rd_cyc;
    return 32'($clog2(m)) + 32'd1;
  endfunction

endpackage

// File: rtl/bidir_sync.sv
// Per-bit 2-flop synchroniser for pad input data, async reset to zero.
module bidir_sync #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/bidir_port_ctrl.sv
// Half-duplex parallel port controller: serialises core writes/reads into timed
// bus cycles with turnaround gaps. Optional input synchroniser: BIDIR_PORT_SYNC_EN.
module bidir_port_ctrl
  import bidir_port_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned HOLD_CYC = 2,
  parameter int unsigned TURN_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             pad_en,
  output logic [WIDTH-1:0] pad_dout,
  input  logic [WIDTH-1:0] pad_din,
  output logic             pad_stb,
  output logic             pad_rd
);

  localparam int unsigned RD_CYC = TURN_CYC + SYNC_STAGES + 1;
  localparam int unsigned CNT_W  = cnt_width(HOLD_CYC, RD_CYC);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   pad_dout_q, pad_dout_d;
  logic [WIDTH-1:0]   rd_data_q, rd_data_d;
  logic               pad_en_q, pad_en_d;
  logic               pad_stb_q, pad_stb_d;
  logic               pad_rd_q, pad_rd_d;
  logic               rd_valid_q, rd_valid_d;
  logic               busy_q, busy_d;
  logic               wr_ready_q, wr_ready_d;
  logic [WIDTH-1:0]   din_s;

`ifdef BIDIR_PORT_SYNC_EN
  bidir_sync #(.WIDTH(WIDTH)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pad_din),
    .q_o   (din_s)
  );
`else
  assign din_s = pad_din;
`endif

  // Next state and counter; outputs are decoded from the next state so they register with it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pad_dout_d = pad_dout_q;
    rd_data_d  = rd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_ready_q && wr_valid) begin
          state_d    = ST_DRIVE;
          cnt_d      = CNT_W'(HOLD_CYC - 1);
          pad_dout_d = wr_data;
        end else if (wr_ready_q && rd_req) begin
          state_d = ST_READ;
          cnt_d   = CNT_W'(RD_CYC - 1);
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          state_d = ST_TURN;
          cnt_d   = CNT_W'(TURN_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_TURN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_READ: begin
        if (cnt_q == '0) begin
          state_d   = ST_CAPTURE;
          cnt_d     = '0;
          rd_data_d = din_s;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    pad_en_d   = (state_d == ST_DRIVE);
    pad_stb_d  = (state_d == ST_DRIVE);
    pad_rd_d   = (state_d == ST_READ);
    rd_valid_d = (state_d == ST_CAPTURE);
    busy_d     = (state_d != ST_IDLE);
    wr_ready_d = (state_d == ST_IDLE);
  end

  // Async reset releases the bus immediately, without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pad_dout_q <= '0;
      rd_data_q  <= '0;
      pad_en_q   <= 1'b0;
      pad_stb_q  <= 1'b0;
      pad_rd_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pad_dout_q <= pad_dout_d;
      rd_data_q  <= rd_data_d;
      pad_en_q   <= pad_en_d;
      pad_stb_q  <= pad_stb_d;
      pad_rd_q   <= pad_rd_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  assign wr_ready = wr_ready_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign busy     = busy_q;
  assign pad_en   = pad_en_q;
  assign pad_dout = pad_dout_q;
  assign pad_stb  = pad_stb_q;
  assign pad_rd   = pad_rd_q;

endmodule

// File: tb/tb_bidir_port_ctrl.sv
// Directed self-checking bench for bidir_port_ctrl; follows BIDIR_PORT_SYNC_EN for read latency.
module tb_bidir_port_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned HOLD  = 2;
  localparam int unsigned TURN  = 1;
`ifdef BIDIR_PORT_SYNC_EN
  localparam int unsigned SYNC  = 2;
`else
  localparam int unsigned SYNC  = 0;
`endif
  localparam int unsigned RD    = TURN + SYNC + 1;

  logic             clk;
  logic             rst_n;
  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic             rd_req;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             pad_en;
  logic [WIDTH-1:0] pad_dout;
  logic [WIDTH-1:0] pad_din;
  logic             pad_stb;
  logic             pad_rd;

  int n_cmp = 0;
  int n_err = 0;

  bidir_port_ctrl #(.WIDTH(WIDTH), .HOLD_CYC(HOLD), .TURN_CYC(TURN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_req   (rd_req),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .busy     (busy),
    .pad_en   (pad_en),
    .pad_dout (pad_dout),
    .pad_din  (pad_din),
    .pad_stb  (pad_stb),
    .pad_rd   (pad_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".pad_en"},   32'(pad_en),   32'd0);
    chk({tag, ".pad_dout"}, 32'(pad_dout), 32'd0);
    chk({tag, ".pad_stb"},  32'(pad_stb),  32'd0);
    chk({tag, ".pad_rd"},   32'(pad_rd),   32'd0);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, ".rd_data"},  32'(rd_data),  32'd0);
    chk({tag, ".busy"},     32'(busy),     32'd0);
    chk({tag, ".wr_ready"}, 32'(wr_ready), 32'd0);
  endtask

  initial begin
    int  last_en, first_rd, ovl, rv_seen;
    bit  sent;
    logic [WIDTH-1:0] rv_data;

    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_req   = 1'b0;
    pad_din  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset.wr_ready", 32'(wr_ready), 32'd1);
    chk("post_reset.busy",     32'(busy),     32'd0);

    // Basic write: HOLD cycles driving, TURN cycles released, then ready
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    for (int i = 1; i <= int'(HOLD + TURN + 1); i++) begin
      @(negedge clk);
      wr_valid = 1'b0;
      chk($sformatf("wr.c%0d.pad_en", i),   32'(pad_en),   32'(i <= int'(HOLD)));
      chk($sformatf("wr.c%0d.pad_stb", i),  32'(pad_stb),  32'(i <= int'(HOLD)));
      chk($sformatf("wr.c%0d.pad_dout", i), 32'(pad_dout), 32'h0000_00A5);
      chk($sformatf("wr.c%0d.wr_ready", i), 32'(wr_ready), 32'(i == int'(HOLD + TURN + 1)));
      chk($sformatf("wr.c%0d.busy", i),     32'(busy),     32'(i <= int'(HOLD + TURN)));
      chk($sformatf("wr.c%0d.pad_rd", i),   32'(pad_rd),   32'd0);
    end

    // Basic read: pad_rd for RD cycles, rd_valid in the following cycle
    pad_din = 8'h3C;
    rd_req  = 1'b1;
    for (int i = 1; i <= int'(RD + 1); i++) begin
      @(negedge clk);
      rd_req = 1'b0;
      chk($sformatf("rd.c%0d.pad_rd", i),   32'(pad_rd),   32'(i <= int'(RD)));
      chk($sformatf("rd.c%0d.rd_valid", i), 32'(rd_valid), 32'(i == int'(RD + 1)));
      chk($sformatf("rd.c%0d.pad_en", i),   32'(pad_en),   32'd0);
    end
    chk("rd.rd_data", 32'(rd_data), 32'h0000_003C);
    pad_din = 8'hFF;
    @(negedge clk);
    chk("rd.hold.rd_valid", 32'(rd_valid), 32'd0);
    chk("rd.hold.rd_data",  32'(rd_data),  32'h0000_003C);
    chk("rd.hold.wr_ready", 32'(wr_ready), 32'd1);

    // Simultaneous write+read: write wins, read dropped; rd_req held into DRIVE is ignored
    wr_valid = 1'b1;
    wr_data  = 8'h5A;
    rd_req   = 1'b1;
    for (int i = 1; i <= int'(HOLD + TURN + 3); i++) begin
      @(negedge clk);
      wr_valid = 1'b0;
      if (i >= 2) rd_req = 1'b0;
      chk($sformatf("sim.c%0d.pad_en", i),   32'(pad_en),   32'(i <= int'(HOLD)));
      chk($sformatf("sim.c%0d.pad_rd", i),   32'(pad_rd),   32'd0);
      chk($sformatf("sim.c%0d.rd_valid", i), 32'(rd_valid), 32'd0);
    end
    chk("sim.pad_dout", 32'(pad_dout), 32'h0000_005A);
    chk("sim.rd_data",  32'(rd_data),  32'h0000_003C);

    // Write then read back-to-back in the first IDLE cycle
    last_en  = 0;
    first_rd = 0;
    ovl      = 0;
    rv_seen  = 0;
    sent     = 1'b0;
    rv_data  = '0;
    wr_valid = 1'b1;
    wr_data  = 8'h11;
    pad_din  = 8'hC3;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      wr_valid = 1'b0;
      rd_req   = 1'b0;
      if (pad_en && pad_rd) ovl++;
      if (pad_en) last_en = i;
      if (pad_rd && first_rd == 0) first_rd = i;
      if (rd_valid) begin
        rv_seen++;
        rv_data = rd_data;
      end
      if (!sent && wr_ready) begin
        rd_req = 1'b1;
        sent   = 1'b1;
      end
    end
    chk("w2r.overlap",  32'(ovl),      32'd0);
    chk("w2r.last_en",  32'(last_en),  32'(HOLD));
    chk("w2r.first_rd", 32'(first_rd), 32'(HOLD + TURN + 2));
    chk("w2r.gap_ok",   32'((first_rd - last_en - 1) >= int'(TURN)), 32'd1);
    chk("w2r.rv_count", 32'(rv_seen),  32'd1);
    chk("w2r.rd_data",  32'(rv_data),  32'h0000_00C3);

    // Reset in the second HOLD cycle releases the bus without a clock edge
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("rst_mid.c1.pad_en", 32'(pad_en), 32'd1);
    @(posedge clk);
    #2;
    chk("rst_mid.c2.pad_en", 32'(pad_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel.wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_rel.pad_en",   32'(pad_en),   32'd0);
    chk("rst_rel.rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rel.busy",     32'(busy),     32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bidir_port_ctrl.md
# bidir_port_ctrl

Core-side controller for a half-duplex parallel port built from a bank of bidirectional pad cells, one per data bit, plus output pads for the strobes. It drives the pads' output-enable and output data, and samples their input data. It serialises core write and read requests into timed bus cycles with guaranteed turnaround gaps so the chip and the external device never drive the bus together. It sits between the edge-detection core's host-access logic and the pad ring.

## Interface
- WIDTH, 8, data bus width (bits, one bidirectional pad each)
- HOLD_CYC, 2, cycles write data is driven with pad_stb high; legal range ≥1
- TURN_CYC, 1, bus-release cycles after a write, and device-drive wait cycles before a read sample; legal range ≥1
- clk  input  1  port clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- wr_valid  input  1  core write request
- wr_data  input  WIDTH  write data, sampled on accept
- wr_ready  output  1  high only in IDLE; a write is accepted when wr_valid && wr_ready
- rd_req  input  1  core read request, accepted in IDLE when wr_valid is low
- rd_valid  output  1  one-cycle pulse, rd_data valid
- rd_data  output  WIDTH  last sampled read data; holds until next capture
- busy  output  1  high in every state except IDLE
- pad_en  output  1  pad output enable (1 = chip drives bus)
- pad_dout  output  WIDTH  data to pads
- pad_din  input  WIDTH  data from pads
- pad_stb  output  1  write strobe to device
- pad_rd  output  1  read strobe; device drives bus while high

## Operation
- States: IDLE, DRIVE, TURN, READ, CAPTURE.
- IDLE: pad_en=0, pad_stb=0, pad_rd=0, wr_ready=1. The bus is released by default.
- Arbitration in IDLE: a write wins. rd_req with wr_valid high in the same cycle is dropped. The core must re-request.
- rd_req outside IDLE is ignored. It is not queued.
- Write accept → DRIVE for HOLD_CYC cycles: pad_en=1, pad_dout=registered wr_data, pad_stb=1. Then → TURN.
- TURN lasts TURN_CYC cycles: pad_en=0, pad_stb=0, and pad_dout holds its last value. Then → IDLE.
- Read accept → READ for TURN_CYC+SYNC_STAGES+1 cycles: pad_rd=1 and pad_en=0 throughout. On the last READ cycle the synchroniser output is registered into rd_data. Then → CAPTURE.
- CAPTURE lasts 1 cycle: rd_valid=1, pad_rd=0. Then → IDLE.
- pad_en and pad_rd are never high in the same cycle. A write is always followed by at least TURN_CYC cycles with pad_en=0 before any read strobe.
- There is one shared down-counter, width $clog2(max(HOLD_CYC, TURN_CYC+SYNC_STAGES+1))+1. It is loaded on every state entry and the state advances at count 0.
- All outputs are registered.

## Timing
- Reset values: state IDLE, pad_en=0, pad_dout=0, pad_stb=0, pad_rd=0, rd_valid=0, rd_data=0, busy=0, wr_ready=0 while rst_n is low.
- Reset mid-operation forces pad_en=0 asynchronously, so the bus releases without waiting for clk. Any partial transaction is discarded with no rd_valid.
- Write accepted at edge k: pad_en and pad_stb are high in cycles k+1..k+HOLD_CYC. wr_ready returns high at cycle k+HOLD_CYC+TURN_CYC+1.
- Read accepted at edge k: pad_rd is high in cycles k+1..k+TURN_CYC+SYNC_STAGES+1. rd_valid is high in cycle k+TURN_CYC+SYNC_STAGES+2.
- Back-to-back: a new request can be accepted in the first IDLE cycle.

## Configuration
- BIDIR_PORT_SYNC_EN defined: pad_din passes through a 2-flop per-bit synchroniser, SYNC_STAGES=2. Use this for an asynchronous external device.
- Not defined: pad_din is registered directly into rd_data, SYNC_STAGES=0. Read latency drops by 2 cycles. Use this for a source-synchronous device.

## Structure
- Package bidir_port_pkg contains:
  - the state enum
  - localparam SYNC_STAGES, chosen by BIDIR_PORT_SYNC_EN
  - the counter-width function
- Sub-module bidir_sync: parameterised-width 2-flop synchroniser with async active-low reset to 0. It is instantiated only under BIDIR_PORT_SYNC_EN.

## Test plan
- Reset and write: release reset, then send wr_valid with wr_data=8'hA5 (defaults). Require pad_en=1, pad_dout=A5, pad_stb=1 for exactly 2 cycles, then pad_en=0 for 1 cycle, then wr_ready=1.
- Read with sync: drive pad_din=8'h3C while pad_rd is high and pulse rd_req. Require pad_rd high for 4 cycles, rd_valid in cycle 5 with rd_data=3C, and pad_en=0 throughout.
- Simultaneous requests: assert wr_valid and rd_req in the same IDLE cycle. Require a write cycle only, with no pad_rd and no rd_valid.
- Write immediately followed by read: require at least 1 cycle with both pad_en=0 and pad_rd=0 between them, and never pad_en && pad_rd.
- Reset mid-DRIVE: assert rst_n=0 in the second HOLD cycle. Require pad_en=0 before the next clk edge and all outputs at reset values.
- Without BIDIR_PORT_SYNC_EN: repeat the read test. Require rd_valid in cycle 3 with rd_data equal to pad_din.
